// File: rtl/irq_arbiter_pkg.sv
// Shared constants and FSM encodings for the interrupt arbiter.
package irq_arbiter_pkg;

  localparam int IRQ_VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Circular priority encoder: first set request at or above start_i, wrapping.
import irq_arbiter_pkg::*;

module irq_prio_enc #(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0]   req_i,
  input  logic [IRQ_VEC_W-1:0] start_i,
  output logic [IRQ_VEC_W-1:0] idx_o,
  output logic                 valid_o
);

  always_comb begin
    int j;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      j = int'(start_i) + i;
      if (j >= NUM_IRQ) j = j - NUM_IRQ;
      if (j >= NUM_IRQ) j = j - NUM_IRQ;
      if (!valid_o && req_i[j]) begin
        idx_o   = IRQ_VEC_W'(j);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter between external interrupt sources and the CPU core.
import irq_arbiter_pkg::*;

module irq_arbiter #(
  parameter int NUM_IRQ     = 5,
  parameter int ROUND_ROBIN = 0,
  parameter int ENABLE      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ena_i,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic                 ie_i,
  input  logic                 irq_take_i,
  input  logic                 reti_i,
  output logic                 irq_req_o,
  output logic [IRQ_VEC_W-1:0] irq_vec_o,
  output logic [NUM_IRQ-1:0]   irq_ack_o,
  output logic                 busy_o
);

  localparam logic [IRQ_VEC_W-1:0] PTR_RST = IRQ_VEC_W'(NUM_IRQ - 1);

  irq_state_t                r_state, w_state_nxt;
  logic [IRQ_VEC_W-1:0]      r_vec, w_vec_nxt;
  logic [IRQ_VEC_W-1:0]      r_ptr, w_ptr_nxt;
  logic [NUM_IRQ-1:0]        r_ack, w_ack_nxt;
  logic [IRQ_VEC_W-1:0]      w_start, w_win;
  logic                      w_valid;
  logic [NUM_IRQ-1:0]        w_vec_onehot, w_win_onehot;
  logic                      w_cur_req;

  // Rotating search begins one past the last granted line.
  always_comb begin
    w_start = '0;
    if (ENABLE != 0 && ROUND_ROBIN != 0)
      w_start = (r_ptr == PTR_RST) ? '0 : r_ptr + 1'b1;
  end

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req_i   (irq_i),
    .start_i (w_start),
    .idx_o   (w_win),
    .valid_o (w_valid)
  );

  always_comb begin
    w_vec_onehot = '0;
    w_win_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_vec_onehot[i] = (r_vec == IRQ_VEC_W'(i));
      w_win_onehot[i] = (w_win == IRQ_VEC_W'(i)) && w_valid;
    end
  end

  assign w_cur_req = |(irq_i & w_vec_onehot);

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_ptr_nxt   = r_ptr;
    w_ack_nxt   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (ie_i && w_valid) begin
          w_state_nxt = ST_REQ;
          w_vec_nxt   = w_win;
        end
      end
      ST_REQ: begin
        // Take beats withdrawal; a rising higher-priority line never preempts.
        if (ena_i && irq_take_i) begin
          w_state_nxt = ST_SERVICE;
          w_ack_nxt   = w_vec_onehot;
          w_ptr_nxt   = r_vec;
        end else if (!w_cur_req || !ie_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (ena_i && reti_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_ptr   <= PTR_RST;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    if (ENABLE != 0) begin
      irq_req_o = (r_state == ST_REQ);
      irq_vec_o = r_vec;
      irq_ack_o = r_ack;
      busy_o    = (r_state == ST_SERVICE);
    end else begin
      irq_req_o = (|irq_i) & ie_i;
      irq_vec_o = w_win;
      irq_ack_o = w_win_onehot & {NUM_IRQ{irq_take_i}};
      busy_o    = 1'b0;
    end
  end

endmodule
